exception_handler: RTL

EXCEPTION_HANDLER -- requirements
Module: exception_handler

---
 rtl/exception_handler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/exception_handler.sv
// Trap/return sequencer with supervisor CSRs (sstatus, stvec, sepc, scause).
// Optional macro EXT_INT_EN adds a level-sensitive ext_irq input that traps with cause 8'h89.
module exception_handler #(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        int_signal,
  input  logic [7:0]  scause_in,
  input  logic        mret,
`ifdef EXT_INT_EN
  input  logic        ext_irq,
`endif
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        busy,
  output logic [31:0] sepc,
  output logic [7:0]  scause,
  output logic        sie,
  output logic [1:0]  dbg_state
);

  // Handshake: a redirect is a single-cycle pulse with redirect_valid=1 and
  // no ready; fetch must accept it in that cycle. While busy=1 the upstream
  // pipeline holds and int_signal/mret are ignored.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRAP = 2'd1,
    RET  = 2'd2
  } state_t;

  localparam logic [11:0] ADDR_SSTATUS = 12'h100;
  localparam logic [11:0] ADDR_STVEC   = 12'h105;
  localparam logic [11:0] ADDR_SEPC    = 12'h141;
  localparam logic [11:0] ADDR_SCAUSE  = 12'h142;
  localparam logic [7:0]  IRQ_CAUSE    = 8'h89;

  state_t      state;
  logic [31:0] stvec;
  logic        spie;

  logic        take_exc;
  logic        take_irq;
  logic        take_trap;
  logic        take_ret;
  logic [7:0]  trap_cause;
  logic        wr_sstatus;
  logic        wr_stvec;
  logic        wr_sepc;
  logic        wr_scause;
  logic [31:0] wdata_aligned;
  logic [31:0] stvec_next;
  logic [31:0] sepc_next;

  always_comb begin
    take_exc = ex_valid & int_signal;
`ifdef EXT_INT_EN
    take_irq = ext_irq & sie & ~take_exc;
`else
    take_irq = 1'b0;
`endif
    take_trap  = (state == IDLE) & (take_exc | take_irq);
    take_ret   = (state == IDLE) & ex_valid & mret & ~int_signal & ~take_irq;
    trap_cause = take_exc ? scause_in : IRQ_CAUSE;
  end

  always_comb begin
    wr_sstatus    = csr_we & (csr_addr == ADDR_SSTATUS);
    wr_stvec      = csr_we & (csr_addr == ADDR_STVEC);
    wr_sepc       = csr_we & (csr_addr == ADDR_SEPC);
    wr_scause     = csr_we & (csr_addr == ADDR_SCAUSE);
    wdata_aligned = {csr_wdata[31:2], 2'b00};
    // Values the registers hold after this edge, so a redirect launched on the
    // same edge as a CSR write points where the architectural state points.
    stvec_next    = wr_stvec ? wdata_aligned : stvec;
    sepc_next     = wr_sepc  ? wdata_aligned : sepc;
  end

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      ADDR_SSTATUS: csr_rdata = {26'h0, spie, 3'b000, sie, 1'b0};
      ADDR_STVEC:   csr_rdata = stvec;
      ADDR_SEPC:    csr_rdata = sepc;
      ADDR_SCAUSE:  csr_rdata = {24'h0, scause};
      default:      csr_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      sepc           <= 32'h0;
      scause         <= 8'h0;
      sie            <= 1'b0;
      spie           <= 1'b0;
      stvec          <= TRAP_VECTOR;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
      flush          <= 1'b0;
      busy           <= 1'b0;
    end else begin
      stvec <= stvec_next;
      sepc  <= sepc_next;
      if (wr_sstatus) begin
        sie  <= csr_wdata[1];
        spie <= csr_wdata[5];
      end
      if (wr_scause) scause <= csr_wdata[7:0];

      state          <= IDLE;
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      busy           <= 1'b0;

      // Trap/MRET updates come last so they override a same-cycle CSR write.
      if (take_trap) begin
        sepc           <= ex_pc;
        scause         <= trap_cause;
        spie           <= sie;
        sie            <= 1'b0;
        state          <= TRAP;
        redirect_valid <= 1'b1;
        flush          <= 1'b1;
        busy           <= 1'b1;
        redirect_pc    <= stvec_next;
      end else if (take_ret) begin
        sie            <= spie;
        spie           <= 1'b1;
        state          <= RET;
        redirect_valid <= 1'b1;
        flush          <= 1'b1;
        busy           <= 1'b1;
        redirect_pc    <= sepc_next;
      end
    end
  end

  assign dbg_state = state;

endmodule
